// File: rtl/uart_vector_loader_pkg.sv
// Shared definitions for the UART test-vector loader.
//   state_t      : loader FSM states
//   ACK_BYTE     : response byte for an accepted frame
//   NAK_BYTE     : response byte for a rejected or timed-out frame
//   VEC_W        : width of one test-vector word
//   csum_next()  : running frame checksum update
package uart_vector_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        COUNT = 3'd1,
        DATA  = 3'd2,
        CHECK = 3'd3,
        RESP  = 3'd4
    } state_t;

    localparam logic [7:0] ACK_BYTE = 8'h06;
    localparam logic [7:0] NAK_BYTE = 8'h15;

    localparam int VEC_W = 56;

    function automatic logic [7:0] csum_next(input logic [7:0] csum, input logic [7:0] data);
        return csum ^ data;
    endfunction

endpackage

// File: rtl/uart_vector_loader_vector_word_assembler.sv
// Assembles received bytes into one test-vector word, least significant byte first.
//   clk, rst   : system clock, synchronous active-low reset
//   clear      : restart at byte 0 with an empty word
//   shift_en   : byte_in is the next byte of the current word
//   byte_in    : received data byte
//   word       : assembled word; complete while word_done is high
//   last_byte  : the next shifted byte completes the word
//   word_done  : one-cycle pulse the cycle after the completing byte
module vector_word_assembler
    import uart_vector_loader_pkg::*;
#(
    parameter int WORD_BYTES = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    shift_en,
    input  logic [7:0]              byte_in,
    output logic [WORD_BYTES*8-1:0] word,
    output logic                    last_byte,
    output logic                    word_done
);

    localparam int WORD_W = WORD_BYTES * 8;
    localparam int IDX_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    logic [IDX_W-1:0] byte_idx;

    assign last_byte = (byte_idx == IDX_W'(WORD_BYTES - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            word      <= '0;
            byte_idx  <= '0;
            word_done <= 1'b0;
        end else begin
            word_done <= 1'b0;
            if (clear) begin
                word     <= '0;
                byte_idx <= '0;
            end else if (shift_en) begin
                // New bytes enter at the top, so the first byte ends up in bits 7:0.
                word <= {byte_in, word[WORD_W-1:8]};
                if (last_byte) begin
                    byte_idx  <= '0;
                    word_done <= 1'b1;
                end else begin
                    byte_idx <= byte_idx + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/uart_vector_loader.sv
// Loads framed test vectors from a UART byte stream into a vector memory.
// Frame: HDR_BYTE, N, N*WORD_BYTES data bytes (LSB first), XOR checksum.
// Each frame is answered with ACK or NAK on the transmit side.
//   clk, rst     : system clock, synchronous active-low reset
//   rx_valid     : one-cycle pulse, rx_byte valid
//   rx_byte      : received byte
//   tx_busy      : transmitter busy, no tx_start while high
//   tx_start     : one-cycle transmit request
//   tx_byte      : response byte, stable from tx_start to the next tx_start
//   mem_we       : one-cycle vector memory write strobe
//   mem_addr     : vector index being written
//   mem_din      : vector word being written
//   load_done    : one-cycle pulse when a frame is accepted
//   instr_count  : vector count of the last accepted frame
//   load_error   : sticky NAK flag, cleared by an accepted frame or reset
module uart_vector_loader
    import uart_vector_loader_pkg::*;
#(
    parameter int         WORD_BYTES     = 7,
    parameter logic [7:0] HDR_BYTE       = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 120000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_valid,
    input  logic [7:0]       rx_byte,
    input  logic             tx_busy,
    output logic             tx_start,
    output logic [7:0]       tx_byte,
    output logic             mem_we,
    output logic [7:0]       mem_addr,
    output logic [VEC_W-1:0] mem_din,
    output logic             load_done,
    output logic [7:0]       instr_count,
    output logic             load_error
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t state, state_next;

    logic [7:0]      n_q;
    logic [7:0]      addr_q;
    logic [7:0]      csum_q;
    logic [TO_W-1:0] idle_cnt;
    logic [7:0]      resp_q;
    logic [7:0]      tx_byte_q;
    logic            load_done_q;
    logic            load_error_q;
    logic [7:0]      instr_count_q;

    logic            frame_start;
    logic            data_shift;
    logic            resp_load;
    logic [7:0]      resp_next;
    logic            set_err;
    logic            accept;
    logic            tx_fire;
    logic            timeout;

    logic                    asm_last;
    logic                    word_vld_p1;
    logic [WORD_BYTES*8-1:0] asm_word;

    vector_word_assembler #(
        .WORD_BYTES (WORD_BYTES)
    ) u_asm (
        .clk       (clk),
        .rst       (rst),
        .clear     (frame_start),
        .shift_en  (data_shift),
        .byte_in   (rx_byte),
        .word      (asm_word),
        .last_byte (asm_last),
        .word_done (word_vld_p1)
    );

    // A byte arriving in the expiry cycle wins over the timeout.
    assign timeout = (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1)) && !rx_valid;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        frame_start = 1'b0;
        data_shift  = 1'b0;
        resp_load   = 1'b0;
        resp_next   = NAK_BYTE;
        set_err     = 1'b0;
        accept      = 1'b0;
        tx_fire     = 1'b0;
        case (state)
            IDLE: begin
                if (rx_valid && (rx_byte == HDR_BYTE)) begin
                    state_next = COUNT;
                end
            end
            COUNT: begin
                if (rx_valid) begin
                    if (rx_byte == 8'h00) begin
                        resp_load  = 1'b1;
                        set_err    = 1'b1;
                        state_next = RESP;
                    end else begin
                        frame_start = 1'b1;
                        state_next  = DATA;
                    end
                end else if (timeout) begin
                    resp_load  = 1'b1;
                    set_err    = 1'b1;
                    state_next = RESP;
                end
            end
            DATA: begin
                if (rx_valid) begin
                    data_shift = 1'b1;
                    // Earlier words are already written, so addr_q is the index
                    // of the word this byte belongs to. The final write strobe
                    // lands in the first CHECK cycle.
                    if (asm_last && (addr_q == n_q - 8'd1)) begin
                        state_next = CHECK;
                    end
                end else if (timeout) begin
                    resp_load  = 1'b1;
                    set_err    = 1'b1;
                    state_next = RESP;
                end
            end
            CHECK: begin
                if (rx_valid) begin
                    resp_load = 1'b1;
                    if (rx_byte == csum_q) begin
                        accept    = 1'b1;
                        resp_next = ACK_BYTE;
                    end else begin
                        set_err = 1'b1;
                    end
                    state_next = RESP;
                end else if (timeout) begin
                    resp_load  = 1'b1;
                    set_err    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                // Gated by rst so a reset in RESP never leaks a transmit request.
                if (!tx_busy && rst) begin
                    tx_fire    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            n_q           <= '0;
            addr_q        <= '0;
            csum_q        <= '0;
            idle_cnt      <= '0;
            resp_q        <= '0;
            tx_byte_q     <= '0;
            load_done_q   <= 1'b0;
            load_error_q  <= 1'b0;
            instr_count_q <= '0;
        end else begin
            load_done_q <= 1'b0;

            if (rx_valid || (state == IDLE) || (state == RESP)) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + TO_W'(1);
            end

            if (frame_start) begin
                n_q    <= rx_byte;
                addr_q <= '0;
                csum_q <= '0;
            end else begin
                if (data_shift) begin
                    csum_q <= csum_next(csum_q, rx_byte);
                end
                if (word_vld_p1) begin
                    addr_q <= addr_q + 8'd1;
                end
            end

            if (resp_load) begin
                resp_q <= resp_next;
            end

            if (set_err) begin
                load_error_q <= 1'b1;
            end else if (accept) begin
                load_error_q  <= 1'b0;
                instr_count_q <= n_q;
                load_done_q   <= 1'b1;
            end

            if (tx_fire) begin
                tx_byte_q <= resp_q;
            end
        end
    end

    // tx_start follows tx_busy combinationally so the request goes out in the
    // first idle cycle; tx_byte switches to the new response in that same cycle.
    assign tx_start    = tx_fire;
    assign tx_byte     = tx_fire ? resp_q : tx_byte_q;
    assign mem_we      = word_vld_p1 && rst;
    assign mem_addr    = addr_q;
    assign mem_din     = asm_word;
    assign load_done   = load_done_q;
    assign load_error  = load_error_q;
    assign instr_count = instr_count_q;

endmodule
